nibble_packer: RTL and testbench
================================

NIBBLE_PACKER -- requirements
Module: nibble_packer

Interface
REQ-001 The block SHALL have parameter OUT_DEPTH, default 2, giving the number of output FIFO entries (a power of 2, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream 4-bit transform stage presents a nibble.
REQ-005 The block SHALL have port in_data, input, 4 bits: nibble from the upstream stage (its q output).
REQ-006 The block SHALL have port in_ready, output, 1 bit: block accepts in_data this cycle.
REQ-007 The block SHALL have port flush, input, 1 bit: single-cycle request to emit the partial word.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data and out_count are valid.
REQ-009 The block SHALL have port out_data, output, 16 bits: packed word, first nibble in bits [3:0].
REQ-010 The block SHALL have port out_count, output, 3 bits: number of valid nibbles in out_data, range 1..4.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream consumes the head word.
REQ-012 The block SHALL have port words_out, output, 8 bits: count of words popped.

Function
REQ-013 A nibble SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; in_data is ignored otherwise.
REQ-014 The k-th accepted nibble of a word (k=0..3) SHALL be written to bits [4k+3:4k]; unfilled bits SHALL be 0.
REQ-015 The packer FSM SHALL have three states: EMPTY (fill count 0), FILLING (fill count 1..3), and FLUSH_WAIT.
REQ-016 On acceptance of the 4th nibble, the word SHALL be pushed with count 4 on that same edge; FSM goes to EMPTY; out_valid is high in the following cycle if the FIFO was empty.
REQ-017 in_ready SHALL be 1 in EMPTY/FILLING when fill count is not 3 or the FIFO is not full, and 0 in FLUSH_WAIT; it SHALL depend on registered state only.
REQ-018 flush with fill count 0 and no nibble accepted SHALL be ignored.
REQ-019 flush in FILLING with the FIFO not full SHALL push the partial word with out_count equal to the fill count; FSM goes to EMPTY.
REQ-020 flush coincident with an accepted nibble SHALL include that nibble first; if this completes 4 nibbles, exactly one word (count 4) SHALL be pushed.
REQ-021 flush in FILLING with the FIFO full SHALL enter FLUSH_WAIT; the partial word SHALL be pushed on the first edge where the FIFO is not full, and the FSM then goes to EMPTY.
REQ-022 The FIFO SHALL push only when not full, judged on registered occupancy; a pop is out_valid=1 and out_ready=1.
REQ-023 A simultaneous push and pop SHALL leave occupancy unchanged; words SHALL leave in push order.
REQ-024 out_valid SHALL equal (occupancy != 0).
REQ-025 out_data and out_count SHALL be held stable while out_valid=1 and out_ready=0.
REQ-026 out_data and out_count SHALL read 0 when the FIFO is empty.
REQ-027 words_out SHALL increment by 1 per pop, wrapping 255 -> 0.

Reset
REQ-028 While rst=1: FSM in EMPTY, fill count 0, partial word 0, FIFO empty, out_valid=0, out_data=0, out_count=0, words_out=0, in_ready=1.
REQ-029 Reset mid-word or mid-FLUSH_WAIT SHALL discard the partial word and all FIFO contents, with no output afterward.

Verification
REQ-030 Bench SHALL cover: out_ready=1, nibbles 1,2,3,4 on consecutive cycles -> one cycle after the 4th accept, out_valid=1, out_data=16'h4321, out_count=4, then words_out=1.
REQ-031 Bench SHALL cover: nibbles A,B then flush -> out_data=16'h00BA, out_count=2.
REQ-032 Bench SHALL cover: out_ready=0, continuous nibbles with OUT_DEPTH=2 -> in_ready=0 after 11 accepted nibbles; then out_ready=1 -> words in order, in_ready returns 1.
REQ-033 Bench SHALL cover: FIFO full, fill count 1 (nibble 5), flush -> FLUSH_WAIT with in_ready=0; after one pop, word 16'h0005 with count 1 is pushed, then EMPTY.
REQ-034 Bench SHALL cover: nibbles 1,2,3 then nibble 4 with flush in the same cycle -> exactly one word 16'h4321 with count 4 and no empty word.
REQ-035 Bench SHALL cover: rst pulsed after 2 nibbles and with 1 word queued -> out_valid=0 and words_out=0; next nibbles 5,6,7,8 -> 16'h8765.

Source files
------------

// File: rtl/nibble_packer.sv
// Packs accepted 4-bit nibbles into 16-bit words (first nibble in [3:0]) and
// queues them in a small output FIFO, with flush support for partial words.
module nibble_packer #(
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  in_data,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic [2:0]  out_count,
    input  logic        out_ready,
    output logic [7:0]  words_out
);

    localparam int unsigned AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FLUSH_WAIT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [1:0]    fill;
    logic [1:0]    fill_next;
    logic [15:0]   partial;
    logic [15:0]   partial_next;

    logic [15:0]   mem_data  [OUT_DEPTH];
    logic [2:0]    mem_count [OUT_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;

    logic          full;
    logic          empty;
    logic          accept;
    logic          push;
    logic          pop;
    logic [15:0]   push_data;
    logic [2:0]    push_count;
    logic [15:0]   merged;
    logic [15:0]   word;
    logic [2:0]    fill_inc;

    assign full  = (occ == CW'(OUT_DEPTH));
    assign empty = (occ == '0);

    // Ready depends only on registered state so upstream sees no comb path.
    assign in_ready = (state != FLUSH_WAIT) && ((fill != 2'd3) || !full);
    assign accept   = in_valid && in_ready;
    assign merged   = partial | (16'(in_data) << {fill, 2'b00});
    assign word     = accept ? merged : partial;
    assign fill_inc = 3'(fill) + 3'(accept);
    assign pop      = !empty && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            fill    <= 2'd0;
            partial <= 16'd0;
        end else begin
            state   <= state_next;
            fill    <= fill_next;
            partial <= partial_next;
        end
    end

    always_comb begin
        state_next   = state;
        fill_next    = fill;
        partial_next = partial;
        push         = 1'b0;
        push_data    = partial;
        push_count   = 3'(fill);
        case (state)
            EMPTY, FILLING: begin
                if (fill_inc == 3'd4) begin
                    // A completed word absorbs any coincident flush.
                    push         = 1'b1;
                    push_data    = merged;
                    push_count   = 3'd4;
                    state_next   = EMPTY;
                    fill_next    = 2'd0;
                    partial_next = 16'd0;
                end else if (flush && (fill_inc != 3'd0)) begin
                    if (!full) begin
                        push         = 1'b1;
                        push_data    = word;
                        push_count   = fill_inc;
                        state_next   = EMPTY;
                        fill_next    = 2'd0;
                        partial_next = 16'd0;
                    end else begin
                        state_next   = FLUSH_WAIT;
                        fill_next    = fill_inc[1:0];
                        partial_next = word;
                    end
                end else if (accept) begin
                    state_next   = FILLING;
                    fill_next    = fill_inc[1:0];
                    partial_next = merged;
                end
            end
            FLUSH_WAIT: begin
                if (!full) begin
                    push         = 1'b1;
                    state_next   = EMPTY;
                    fill_next    = 2'd0;
                    partial_next = 16'd0;
                end
            end
            default: begin
                state_next   = EMPTY;
                fill_next    = 2'd0;
                partial_next = 16'd0;
            end
        endcase
    end

    // Storage needs no reset: reads are masked by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr]  <= push_data;
            mem_count[wr_ptr] <= push_count;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            words_out <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                words_out <= words_out + 8'd1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign out_valid = !empty;
    assign out_data  = empty ? 16'd0 : mem_data[rd_ptr];
    assign out_count = empty ? 3'd0  : mem_count[rd_ptr];

endmodule

// File: tb/tb_nibble_packer.sv
// Bench for nibble_packer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_nibble_packer;

    localparam int unsigned DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_data;
    logic [2:0]  out_count;
    logic        out_ready;
    logic [7:0]  words_out;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    nibble_packer #(.OUT_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ready (out_ready),
        .words_out (words_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending nibbles, output word queue, flush-pending flag.
    logic [3:0]  pend[$];
    logic [15:0] qd[$];
    logic [2:0]  qc[$];
    bit          m_fw;
    logic [7:0]  m_words;

    function automatic logic [15:0] pack_pend();
        logic [15:0] w = 16'd0;
        foreach (pend[k]) w = w | (16'(pend[k]) << (4 * k));
        return w;
    endfunction

    function automatic bit model_ready();
        return !m_fw && ((pend.size() != 3) || (qd.size() < DEPTH));
    endfunction

    bit          m_full, m_acc, m_pop, m_push;
    logic [15:0] m_pd;
    logic [2:0]  m_pc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pend.delete(); qd.delete(); qc.delete();
            m_fw = 0;
            m_words = 8'd0;
        end else begin
            m_full = (qd.size() == DEPTH);
            m_acc  = in_valid && model_ready();
            m_pop  = (qd.size() != 0) && out_ready;
            m_push = 0;
            if (m_acc) pend.push_back(in_data);
            if (pend.size() == 4) begin
                m_push = 1; m_pd = pack_pend(); m_pc = 3'd4;
            end else if (m_fw) begin
                if (!m_full) begin
                    m_push = 1; m_pd = pack_pend(); m_pc = 3'(pend.size());
                    m_fw = 0;
                end
            end else if (flush && pend.size() > 0) begin
                if (!m_full) begin
                    m_push = 1; m_pd = pack_pend(); m_pc = 3'(pend.size());
                end else begin
                    m_fw = 1;
                end
            end
            if (m_push) pend.delete();
            if (m_pop) begin
                void'(qd.pop_front()); void'(qc.pop_front());
                m_words = m_words + 8'd1;
            end
            if (m_push) begin
                qd.push_back(m_pd); qc.push_back(m_pc);
            end
        end
    end

    // Cycle compare, slightly after the falling edge.
    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(qd.size() != 0));
            check("out_data",  32'(out_data),  (qd.size() != 0) ? 32'(qd[0]) : 32'd0);
            check("out_count", 32'(out_count), (qc.size() != 0) ? 32'(qc[0]) : 32'd0);
            check("in_ready",  32'(in_ready),  32'(model_ready()));
            check("words_out", 32'(words_out), 32'(m_words));
        end
    end

    task automatic send(input logic [3:0] nib, input logic fl);
        in_valid = 1'b1; in_data = nib; flush = fl;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'd0; flush = 1'b0; out_ready = 1'b0;
        idle(2);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_words_out", 32'(words_out), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        chk_en = 1;
        idle(1);

        // Full word 1,2,3,4 with downstream ready.
        out_ready = 1'b1;
        send(4'h1, 0); send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
        check("w4_valid", 32'(out_valid), 32'd1);
        check("w4_data",  32'(out_data),  32'h4321);
        check("w4_count", 32'(out_count), 32'd4);
        idle(1);
        check("w4_words", 32'(words_out), 32'd1);

        // Partial flush A,B.
        out_ready = 1'b0;
        send(4'hA, 0); send(4'hB, 0);
        pulse_flush();
        check("fl_data",  32'(out_data),  32'h00BA);
        check("fl_count", 32'(out_count), 32'd2);
        out_ready = 1'b1;
        idle(1);
        check("fl_words", 32'(words_out), 32'd2);
        check("fl_empty", 32'(out_valid), 32'd0);
        pulse_flush();
        check("flush_empty_ignored", 32'(out_valid), 32'd0);

        // Backpressure: 11 nibbles fill FIFO plus 3 in the packer.
        out_ready = 1'b0;
        for (int i = 1; i <= 11; i++) send(4'(i), 0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head",     32'(out_data), 32'h4321);
        out_ready = 1'b1;
        idle(1);
        check("bp_head2",    32'(out_data), 32'h8765);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        pulse_flush();
        idle(3);

        // Flush while FIFO is full waits for space.
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(4'(i), 0);
        send(4'h5, 0);
        pulse_flush();
        check("fw_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check("fw_head", 32'(out_data), 32'h8765);
        idle(1);
        check("fw_ready_back", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        idle(1);
        check("fw_data",  32'(out_data),  32'h0005);
        check("fw_count", 32'(out_count), 32'd1);
        idle(2);

        // Fourth nibble with coincident flush yields exactly one word.
        out_ready = 1'b0;
        send(4'h1, 0); send(4'h2, 0); send(4'h3, 0); send(4'h4, 1);
        check("cf_data",  32'(out_data),  32'h4321);
        check("cf_count", 32'(out_count), 32'd4);
        out_ready = 1'b1;
        idle(1);
        check("cf_single", 32'(out_valid), 32'd0);

        // Reset mid-word with one word queued.
        out_ready = 1'b0;
        send(4'h1, 0); send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
        send(4'h1, 0); send(4'h2, 0);
        rst = 1'b1;
        idle(1);
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_words", 32'(words_out), 32'd0);
        rst = 1'b0;
        idle(1);
        send(4'h5, 0); send(4'h6, 0); send(4'h7, 0); send(4'h8, 0);
        check("mr_data",  32'(out_data),  32'h8765);
        check("mr_count", 32'(out_count), 32'd4);
        out_ready = 1'b1;
        idle(2);

        // Mixed random traffic, model-checked.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom);
            flush     = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        // Streaming long enough to wrap words_out.
        flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            in_data = 4'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        idle(4);
        check("wrap_seen", 32'(m_words < 8'd200), 32'd1);

        chk_en = 0;
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
